// File: rtl/fft_peak_pkg.sv
// Shared definitions for the FFT peak detector and the downstream note mapper:
// compare-stage states, magnitude width helper and default search window.
package fft_peak_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } cmp_state_t;

    localparam int unsigned DEF_BIN_MIN   = 4;
    localparam int unsigned DEF_BIN_MAX   = 400;
    localparam int unsigned DEF_THRESHOLD = 1 << 20;

    // |X|^2 of two DATA_W-bit signed parts needs one carry bit over a square
    function automatic int mag_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |X|^2 pipeline: squares in stage 1, full-width sum in stage 2.
// Beat tags (valid, sop, eop, bin index) travel alongside the data.
module fft_mag_sq
    import fft_peak_pkg::*;
#(
    parameter int DATA_W = 25,
    parameter int BIN_W  = 14
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic [BIN_W-1:0]           in_bin,
    input  logic signed [DATA_W-1:0]   in_real,
    input  logic signed [DATA_W-1:0]   in_imag,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [BIN_W-1:0]           out_bin,
    output logic [mag_w(DATA_W)-1:0]   out_mag
);

    localparam int SQ_W = 2 * DATA_W;

    logic signed [SQ_W-1:0] re_ext, im_ext;
    logic        [SQ_W-1:0] re_prod, im_prod;
    logic        [SQ_W-1:0] re_sq, im_sq;
    logic                   s1_valid, s1_sop, s1_eop;
    logic [BIN_W-1:0]       s1_bin;

    // A square is never negative and fits in SQ_W bits, so the low half of
    // the sign-extended product is the exact unsigned result.
    assign re_ext  = {{DATA_W{in_real[DATA_W-1]}}, in_real};
    assign im_ext  = {{DATA_W{in_imag[DATA_W-1]}}, in_imag};
    assign re_prod = re_ext * re_ext;
    assign im_prod = im_ext * im_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_bin   <= '0;
            re_sq    <= '0;
            im_sq    <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_sop   <= in_sop;
            s1_eop   <= in_eop;
            s1_bin   <= in_bin;
            re_sq    <= re_prod;
            im_sq    <= im_prod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_bin   <= '0;
            out_mag   <= '0;
        end else begin
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            out_bin   <= s1_bin;
            out_mag   <= {1'b0, re_sq} + {1'b0, im_sq};
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over FFT bins inside [BIN_MIN, BIN_MAX] with note flag.
// Define FFT_PEAK_STABLE_EN to require STABLE_FRAMES matching frames for note_present.
module fft_peak_detector
    import fft_peak_pkg::*;
#(
    parameter int          DATA_W        = 25,
    parameter int          BIN_W         = 14,
    parameter int unsigned BIN_MIN       = DEF_BIN_MIN,
    parameter int unsigned BIN_MAX       = DEF_BIN_MAX,
    parameter int unsigned THRESHOLD     = DEF_THRESHOLD,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fft_source_valid,
    output logic                       fft_source_ready,
    input  logic                       fft_source_sop,
    input  logic                       fft_source_eop,
    input  logic signed [DATA_W-1:0]   fft_source_real,
    input  logic signed [DATA_W-1:0]   fft_source_imag,
    output logic                       peak_valid,
    output logic [BIN_W-1:0]           peak_bin,
    output logic [mag_w(DATA_W)-1:0]   peak_mag,
    output logic                       note_present,
    output logic                       frame_error
);

    localparam int               MAG_W  = mag_w(DATA_W);
    localparam logic [BIN_W-1:0] BIN_LO = BIN_W'(BIN_MIN);
    localparam logic [BIN_W-1:0] BIN_HI = BIN_W'(BIN_MAX);
    localparam logic [MAG_W-1:0] THR    = MAG_W'(THRESHOLD);

    logic             accept;
    logic [BIN_W-1:0] bin_cnt, bin_cur;

    logic             m_valid, m_sop, m_eop;
    logic [BIN_W-1:0] m_bin;
    logic [MAG_W-1:0] m_mag;

    cmp_state_t       state, state_next;
    logic             init_max, cmp_en, report, err;
    logic             in_win, take;
    logic [MAG_W-1:0] max_mag, base_max;
    logic [BIN_W-1:0] max_bin, base_bin;
    logic             report_r;
    logic             note_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fft_source_ready <= 1'b0;
        else          fft_source_ready <= 1'b1;
    end

    assign accept  = fft_source_valid && fft_source_ready;
    assign bin_cur = fft_source_sop ? '0 : bin_cnt;

    // bin_cnt holds the index the next non-sop beat will carry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt <= '0;
        end else if (accept) begin
            bin_cnt <= (&bin_cur) ? bin_cur : bin_cur + 1'b1;
        end
    end

    fft_mag_sq #(
        .DATA_W (DATA_W),
        .BIN_W  (BIN_W)
    ) u_mag_sq (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_sop    (fft_source_sop),
        .in_eop    (fft_source_eop),
        .in_bin    (bin_cur),
        .in_real   (fft_source_real),
        .in_imag   (fft_source_imag),
        .out_valid (m_valid),
        .out_sop   (m_sop),
        .out_eop   (m_eop),
        .out_bin   (m_bin),
        .out_mag   (m_mag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        init_max   = 1'b0;
        cmp_en     = 1'b0;
        report     = 1'b0;
        err        = 1'b0;
        if (m_valid) begin
            case (state)
                IDLE: begin
                    if (m_sop) begin
                        init_max   = 1'b1;
                        cmp_en     = 1'b1;
                        report     = m_eop;
                        state_next = m_eop ? IDLE : ACC;
                    end else if (m_eop) begin
                        err = 1'b1;
                    end
                end
                ACC: begin
                    // an sop here restarts the search from this very beat
                    cmp_en   = 1'b1;
                    init_max = m_sop;
                    err      = m_sop;
                    report   = m_eop;
                    if (m_eop) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        base_max = init_max ? '0 : max_mag;
        base_bin = init_max ? BIN_LO : max_bin;
        in_win   = (m_bin >= BIN_LO) && (m_bin <= BIN_HI);
        take     = cmp_en && in_win && (m_mag > base_max);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_mag     <= '0;
            max_bin     <= '0;
            report_r    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            report_r    <= report;
            frame_error <= err;
            if (cmp_en) begin
                max_mag <= take ? m_mag : base_max;
                max_bin <= take ? m_bin : base_bin;
            end
        end
    end

`ifdef FFT_PEAK_STABLE_EN
    localparam int               CNT_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

    logic [CNT_W-1:0] stable_cnt, stable_cnt_next;
    logic             above;

    // peak_bin still holds the previous frame's result when report_r is high
    always_comb begin
        above = (max_mag >= THR);
        if (above && (max_bin == peak_bin))
            stable_cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
        else if (above)
            stable_cnt_next = CNT_W'(1);
        else
            stable_cnt_next = '0;
        note_next = (stable_cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      stable_cnt <= '0;
        else if (err)      stable_cnt <= '0;
        else if (report_r) stable_cnt <= stable_cnt_next;
    end
`else
    assign note_next = (max_mag >= THR);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_valid   <= 1'b0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            note_present <= 1'b0;
        end else begin
            peak_valid <= report_r;
            if (report_r) begin
                peak_bin     <= max_bin;
                peak_mag     <= max_mag;
                note_present <= note_next;
            end
        end
    end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Streaming consumer placed directly downstream of the FFT wrapper. It accepts one frame of complex FFT bins over the FFT source handshake and computes |X|² per bin in a short pipeline. It tracks the strongest bin inside a configurable guitar-frequency window and reports bin index, magnitude and a note-present flag once per frame. The note-mapping logic uses these results.

## Interface
Parameters:
- DATA_W, 25: width of signed real/imag input.
- BIN_W, 14: width of bin index; matches fftpts width.
- BIN_MIN, 4: lowest bin considered for the peak.
- BIN_MAX, 400: highest bin considered for the peak.
- THRESHOLD, 1<<20: minimum |X|² for a note to be present.
- STABLE_FRAMES, 3: consecutive-frame count used only under FFT_PEAK_STABLE_EN.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fft_source_valid  in  1  input beat valid.
- fft_source_ready  out  1  sink ready; low in reset, high from the first clk edge after reset_n deasserts.
- fft_source_sop  in  1  first bin of frame.
- fft_source_eop  in  1  last bin of frame.
- fft_source_real  in  DATA_W  signed real part.
- fft_source_imag  in  DATA_W  signed imag part.
- peak_valid  out  1  one-cycle result strobe.
- peak_bin  out  BIN_W  index of strongest in-window bin.
- peak_mag  out  2*DATA_W+1  |X|² of that bin, unsigned.
- note_present  out  1  note decision for the reported frame.
- frame_error  out  1  one-cycle pulse on a protocol error.

## Operation
- Beats are accepted when valid && ready. The block never back-pressures after reset.
- Stage 1 registers re², im², each 2*DATA_W bits unsigned. Stage 2 registers their sum, 2*DATA_W+1 bits, with no truncation.
- Tags travel with the data through both stages: sop, eop, valid, bin index.
- Bin counter: cleared to 0 on an sop beat and incremented on each subsequent accepted beat. It saturates at all-ones.
- Compare stage FSM:
  - IDLE: wait for a tagged sop, then go to ACC. Non-sop beats are dropped silently.
  - ACC: on each beat with BIN_MIN ≤ bin ≤ BIN_MAX and mag > max, load max and max_bin. The comparison is strict, so on equal magnitudes the lowest bin wins.
  - The sop beat initialises max = 0 and max_bin = BIN_MIN, then is itself compared.
  - On a tagged eop: drive peak_valid with the results and return to IDLE.
  - A beat carrying both sop and eop forms a single-bin frame and reports immediately.
- Protocol errors, each pulsing frame_error for one cycle:
  - sop while in ACC: discard the current frame and start a new one from this beat.
  - eop while in IDLE: ignore the beat.
- Without the stable feature, note_present = (max ≥ THRESHOLD), valid at the peak_valid cycle.
- peak_bin, peak_mag and note_present hold their values between strobes.
- Reset values: all outputs 0, FSM in IDLE, pipeline valid tags cleared.
- Asserting reset mid-frame discards the partial frame, and no strobe is issued.

## Timing
- Latency: an eop beat accepted at rising edge T gives peak_valid high for exactly the cycle following edge T+3.
- Back-to-back frames (sop in the cycle right after eop) are fully supported with no bubble.
- Throughput: one bin per clock.
- Beats with valid low are ignored. The pipeline advances with valid tags cleared.
- Gaps inside a frame are allowed.

## Configuration
- FFT_PEAK_STABLE_EN defined:
  - A stability counter increments when a reported frame has (max ≥ THRESHOLD) and the same peak_bin as the previous frame. Otherwise it resets to 1 if above threshold, or to 0 if below.
  - The counter saturates at STABLE_FRAMES.
  - note_present = (counter == STABLE_FRAMES), updated at peak_valid.
  - A frame_error clears the counter.
- FFT_PEAK_STABLE_EN undefined: no counter; note_present follows the threshold comparison only.

## Structure
- Shared package fft_peak_pkg holds:
  - The FSM state enum (IDLE, ACC).
  - The magnitude width function (2*DATA_W+1).
  - Default BIN_MIN, BIN_MAX and THRESHOLD constants, shared with the note mapper.
- Sub-module fft_mag_sq: the two-stage |X|² pipeline with tag pass-through. The top level contains the bin counter, FSM, comparator and stability logic.

## Test plan
- Frame of 512 bins, all zero except bin 100 with re=1000, im=0 -> peak_valid 3 cycles after eop; peak_bin=100, peak_mag=1_000_000, note_present=0.
- Same frame, but bin 100 has re=-2048, im=2048 -> peak_mag=8_388_608, note_present=1.
- Bins 50 and 60 both with re=im=1500 -> peak_bin=50, because ties resolve to the lowest bin.
- Bin 2 with re=30000 (below BIN_MIN) and bin 200 with re=2000 -> peak_bin=200; bin 401 with a large value is also ignored.
- sop injected at bin 300 of a frame -> frame_error pulses once; the next eop reports only from the new frame. An eop seen while in IDLE -> frame_error, no peak_valid.
- FFT_PEAK_STABLE_EN with STABLE_FRAMES=3, three identical above-threshold frames back-to-back -> note_present goes 0, 0, 1. A fourth frame peaking at a different bin -> note_present=0. Also assert reset_n mid-frame -> all outputs 0 and no strobe.
